noc_vc_read_scheduler: RTL and testbench

Input-port read scheduler for a NoC router: it shares one output link between `NUM_VC` per-VC circular flit buffers. Each cycle it selects one VC by round-robin and asserts that buffer's read strobe, subject to buffer occupancy and downstream on/off permission. It captures the selected flit into an output register. It also tracks head/tail packet framing per VC and flags framing violations. The block sits between the per-VC input buffers and the switch/link stage.

---
 rtl/noc_vc_read_scheduler.sv | 108 ++++++++++
 tb/tb_noc_vc_read_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_read_scheduler.sv
// rtl/noc_vc_read_scheduler.sv - round-robin per-VC buffer read scheduler with framing check
// One flit per cycle is pulled from the first eligible VC after last_grant and registered.
module noc_vc_read_scheduler #(
  parameter int NUM_VC         = 4,
  parameter int VC_W           = $clog2(NUM_VC),
  parameter int flit_Data_noVC = 32
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en_i,
  input  logic [NUM_VC-1:0]                      buf_empty_i,
  input  logic [NUM_VC-1:0]                      downstream_on_i,
  input  logic [NUM_VC-1:0][flit_Data_noVC-1:0]  flit_i,
  input  logic [NUM_VC-1:0][1:0]                 flit_type_i,
  output logic [NUM_VC-1:0]                      read_o,
  output logic                                   out_valid_o,
  output logic [VC_W-1:0]                        out_vc_o,
  output logic [flit_Data_noVC-1:0]              out_flit_o,
  output logic [NUM_VC-1:0]                      vc_active_o,
  output logic                                   err_o
);

  localparam logic [1:0] HEAD     = 2'b00;
  localparam logic [1:0] BODY     = 2'b01;
  localparam logic [1:0] TAIL     = 2'b10;
  localparam logic [1:0] HEADTAIL = 2'b11;

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  vc_state_t         state_q [NUM_VC];
  vc_state_t         state_d [NUM_VC];
  logic              err_d;
  logic [VC_W-1:0]   last_grant;
  logic [NUM_VC-1:0] elig;
  logic              gnt_valid;
  logic [VC_W-1:0]   gnt;
  int                idx;

  // rst_n in the eligibility term keeps read_o low while reset is held
  assign elig = {NUM_VC{en_i & rst_n}} & ~buf_empty_i & downstream_on_i;

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_VC; i++) begin
      idx = (int'(last_grant) + i) % NUM_VC;
      if (!gnt_valid && elig[idx]) begin
        gnt_valid = 1'b1;
        gnt       = VC_W'(idx);
      end
    end
  end

  always_comb begin
    read_o = '0;
    if (gnt_valid) read_o[gnt] = 1'b1;
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) state_d[v] = state_q[v];
    err_d = err_o;
    if (gnt_valid) begin
      if (state_q[gnt] == IDLE) begin
        case (flit_type_i[gnt])
          HEAD:     state_d[gnt] = ACTIVE;
          HEADTAIL: state_d[gnt] = IDLE;
          default:  err_d = 1'b1;
        endcase
      end else begin
        case (flit_type_i[gnt])
          BODY:     state_d[gnt] = ACTIVE;
          TAIL:     state_d[gnt] = IDLE;
          HEAD:     err_d = 1'b1;
          default: begin
            state_d[gnt] = IDLE;
            err_d        = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= IDLE;
      err_o       <= 1'b0;
      last_grant  <= VC_W'(NUM_VC - 1);
      out_valid_o <= 1'b0;
      out_vc_o    <= '0;
      out_flit_o  <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) state_q[v] <= state_d[v];
      err_o       <= err_d;
      out_valid_o <= gnt_valid;
      if (gnt_valid) begin
        last_grant <= gnt;
        out_vc_o   <= gnt;
        out_flit_o <= flit_i[gnt];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) vc_active_o[v] = (state_q[v] == ACTIVE);
  end

endmodule

// File: tb/tb_noc_vc_read_scheduler.sv
// tb/tb_noc_vc_read_scheduler.sv - directed and random checks against a packet-level model
module tb_noc_vc_read_scheduler;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en_i = 1'b0;
  logic [3:0]       buf_empty_i = 4'hF;
  logic [3:0]       downstream_on_i = 4'hF;
  logic [3:0][31:0] flit_i = '0;
  logic [3:0][1:0]  flit_type_i = '0;
  logic [3:0]       read_o;
  logic             out_valid_o;
  logic [1:0]       out_vc_o;
  logic [31:0]      out_flit_o;
  logic [3:0]       vc_active_o;
  logic             err_o;

  noc_vc_read_scheduler dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .buf_empty_i(buf_empty_i),
    .downstream_on_i(downstream_on_i), .flit_i(flit_i), .flit_type_i(flit_type_i),
    .read_o(read_o), .out_valid_o(out_valid_o), .out_vc_o(out_vc_o),
    .out_flit_o(out_flit_o), .vc_active_o(vc_active_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_lg;
  bit   [3:0]  m_act;
  bit          m_err;
  bit          m_valid;
  int          m_vc;
  logic [31:0] m_flit;
  logic [3:0]  last_read;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    for (int i = 1; i <= 4; i++) begin
      int v;
      v = (m_lg + i) % 4;
      if (en_i && !buf_empty_i[v] && downstream_on_i[v]) return v;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lg = 3; m_act = '0; m_err = 0; m_valid = 0; m_vc = 0; m_flit = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_valid"}, out_valid_o, m_valid);
    chk({tag, "_vc"}, out_vc_o, m_vc);
    chk({tag, "_flit"}, out_flit_o, m_flit);
    chk({tag, "_active"}, vc_active_o, m_act);
    chk({tag, "_err"}, err_o, m_err);
  endtask

  // Inputs are set at the falling edge before this is called
  task automatic step(input string tag);
    int g;
    logic [1:0] t;
    #1;
    g = model_grant();
    last_read = read_o;
    chk({tag, "_read"}, read_o, (g < 0) ? 4'b0 : (4'b1 << g));
    @(posedge clk);
    if (g >= 0) begin
      t = flit_type_i[g];
      if (!m_act[g]) begin
        if (t == 2'b00) m_act[g] = 1;
        else if (t != 2'b11) m_err = 1;
      end else begin
        if (t == 2'b10) m_act[g] = 0;
        else if (t == 2'b00) m_err = 1;
        else if (t == 2'b11) begin m_act[g] = 0; m_err = 1; end
      end
      m_lg = g; m_valid = 1; m_vc = g; m_flit = flit_i[g];
    end else begin
      m_valid = 0;
    end
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_read"}, read_o, 4'b0);
    check_regs({tag, "_rst"});
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};
    model_reset();
    en_i = 1'b1; buf_empty_i = 4'b0000; downstream_on_i = 4'hF;
    @(negedge clk);
    do_reset("init");

    // single packet on VC1
    buf_empty_i = 4'b1101;
    flit_i = {32'h0, 32'h0, 32'hA1A1_0001, 32'h0};
    flit_type_i[1] = 2'b00; step("pkt_head");
    chk("pkt_head_read_const", last_read, 4'b0010);
    chk("pkt_head_active", vc_active_o[1], 1'b1);
    flit_type_i[1] = 2'b01; flit_i[1] = 32'hA1A1_0002; step("pkt_body");
    chk("pkt_body_vc", out_vc_o, 2'd1);
    flit_type_i[1] = 2'b10; flit_i[1] = 32'hA1A1_0003; step("pkt_tail");
    chk("pkt_tail_active", vc_active_o[1], 1'b0);
    chk("pkt_tail_err", err_o, 1'b0);

    // round-robin with everything eligible
    do_reset("rr");
    buf_empty_i = 4'b0000; flit_type_i = {4{2'b11}};
    for (int i = 0; i < 6; i++) begin
      flit_i = {32'h30 + i, 32'h20 + i, 32'h10 + i, 32'h00 + i};
      step("rr");
      chk("rr_order", last_read, 4'b1 << order[i]);
    end

    // on/off gating
    buf_empty_i = 4'b1010; downstream_on_i = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step("onoff");
      chk("onoff_vc2_blocked", last_read[2], 1'b0);
    end
    downstream_on_i = 4'hF;
    step("onoff_raise");
    chk("onoff_vc2_granted", last_read, 4'b0100);

    // framing error: BODY on idle VC3 is still forwarded
    do_reset("ferr");
    buf_empty_i = 4'b0111; flit_type_i[3] = 2'b01; flit_i[3] = 32'hDEAD_BEEF;
    step("ferr");
    chk("ferr_flag", err_o, 1'b1);
    chk("ferr_fwd", out_flit_o, 32'hDEAD_BEEF);
    en_i = 1'b0;
    repeat (3) step("ferr_hold");
    chk("ferr_sticky", err_o, 1'b1);
    en_i = 1'b1;
    do_reset("ferr_clear");

    // HEADTAIL on VC0 interleaved with a full packet on VC1
    buf_empty_i = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      flit_type_i[0] = 2'b11;
      flit_type_i[1] = (i < 2) ? 2'b00 : ((i < 4) ? 2'b01 : 2'b10);
      flit_i[0] = 32'h0C00 + i; flit_i[1] = 32'h1C00 + i;
      step("ilv");
      if (i == 1) chk("ilv_vc1_active", vc_active_o, 4'b0010);
    end
    chk("ilv_end_active", vc_active_o, 4'b0000);
    chk("ilv_end_err", err_o, 1'b0);

    // reset mid-packet, then BODY judged from IDLE
    buf_empty_i = 4'b1101; flit_type_i[1] = 2'b00;
    step("mid_head");
    do_reset("mid");
    flit_type_i[1] = 2'b01;
    step("mid_body");
    chk("mid_err", err_o, 1'b1);
    en_i = 1'b0; buf_empty_i = 4'b0000;
    step("en_off");
    chk("en_off_read", last_read, 4'b0);
    chk("en_off_valid", out_valid_o, 1'b0);
    en_i = 1'b1;

    // random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 39) == 0) do_reset("rnd");
      en_i = ($urandom_range(0, 7) != 0);
      buf_empty_i = 4'($urandom);
      downstream_on_i = 4'($urandom);
      for (int v = 0; v < 4; v++) begin
        flit_i[v] = $urandom;
        flit_type_i[v] = 2'($urandom);
      end
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
